eth_tx_arbiter: RTL
===================

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of frame requesters (2..8).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, idle clocks forced between frames (1..255).
REQ-003 SHALL have port sys_clk  input  1  single clock for all logic (125 MHz TX byte clock).
REQ-004 SHALL have port sys_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_txd_in  input  NUM_PORTS*8  requester byte data, port i in bits [8i+7:8i].
REQ-006 SHALL have port s_tvalid_in  input  NUM_PORTS  requester byte valid.
REQ-007 SHALL have port s_tlast_in  input  NUM_PORTS  requester last byte of frame.
REQ-008 SHALL have port s_terr_in  input  NUM_PORTS  requester error marker, forwarded.
REQ-009 SHALL have port s_tready_out  output  NUM_PORTS  requester byte accepted.
REQ-010 SHALL have port phy_txd_out  output  8  byte to PHY TX path.
REQ-011 SHALL have port phy_tvalid_out  output  1  byte valid to PHY TX path.
REQ-012 SHALL have port phy_terr_out  output  1  error to PHY TX path.
REQ-013 SHALL have port phy_tready_in  input  1  PHY TX path accepts byte.
REQ-014 SHALL have port grant_out  output  NUM_PORTS  one-hot current owner, zero when none.
REQ-015 SHALL have port frame_cnt_out  output  16  frames completed, wrapping.
REQ-016 SHALL have port underrun_cnt_out  output  16  frames with mid-frame valid gap, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement FSM states IDLE, XFER, IFG.
REQ-018 IDLE: if any s_tvalid_in bit high, SHALL select the first requesting port in round-robin order starting at (last_grant+1) mod NUM_PORTS, register one-hot grant, go XFER next clock.
REQ-019 Arbitration latency SHALL be exactly one clock from request seen in IDLE to grant_out valid.
REQ-020 last_grant SHALL reset to NUM_PORTS-1 so port 0 has first priority after reset.
REQ-021 XFER: phy_txd_out, phy_tvalid_out, phy_terr_out SHALL combinationally equal the granted port's data, valid, err (terr gated by valid).
REQ-022 XFER: s_tready_out[granted] SHALL equal phy_tready_in; all other s_tready_out bits SHALL be 0.
REQ-023 Grant SHALL hold for the whole frame; no re-arbitration until a handshake (valid & ready) with tlast on the granted port.
REQ-024 On that tlast handshake: frame_cnt_out SHALL increment, FSM SHALL go IFG, IFG counter loads IFG_CYCLES-1, grant_out clears next clock.
REQ-025 IFG: phy_tvalid_out and all s_tready_out SHALL be 0; counter decrements each clock; at 0 FSM SHALL go IDLE.
REQ-026 Total gap from last accepted byte to next frame's first phy_tvalid_out SHALL be IFG_CYCLES+1 clocks minimum (IFG plus one arbitration clock).
REQ-027 XFER with granted s_tvalid_in low after the first accepted byte and before tlast SHALL be recorded as underrun: underrun_cnt_out increments at most once per frame (saturating); transfer continues when valid returns.
REQ-028 Underrun flag SHALL clear on entry to XFER.
REQ-029 Requests from non-granted ports SHALL be ignored (tready 0) and never dropped; they win in later rounds.
REQ-030 Single-byte frame (tvalid & tlast on first beat) SHALL be legal: one XFER byte, then IFG.
REQ-031 phy_tready_in low SHALL stall without changing grant, data, or counters.
REQ-032 Outside XFER, phy_txd_out SHALL be 8'h00, phy_terr_out 0.

Reset
REQ-033 sys_rstn low SHALL asynchronously force FSM IDLE, grant_out 0, all s_tready_out 0, phy_tvalid_out 0, phy_txd_out 8'h00, phy_terr_out 0, IFG counter 0, frame_cnt_out 0, underrun_cnt_out 0, last_grant NUM_PORTS-1.
REQ-034 Reset mid-frame SHALL abandon the frame without completion count; after release the block restarts from IDLE.
REQ-035 Reset release SHALL be synchronised internally (two-stage) so first FSM action occurs on the second rising edge after release.

Verification
REQ-036 Ports 0,1,2 request simultaneously after reset, 4-byte frames, ready=1 -> grants in order 0,1,2; 12 idle clocks plus one arbitration clock between frames; frame_cnt_out=3.
REQ-037 Port 2 frame in progress, port 0 requests mid-frame -> port 0 tready stays 0 until port 2 tlast; port 0 granted after IFG.
REQ-038 phy_tready_in toggled 1,0,1,0 during 6-byte frame -> all 6 bytes delivered in order, no duplication, frame_cnt_out +1.
REQ-039 Granted port drops tvalid for 3 clocks twice within one frame -> underrun_cnt_out +1 exactly, frame completes.
REQ-040 sys_rstn asserted on 3rd byte of a frame -> outputs reach reset values immediately; frame_cnt_out 0; next frame after release granted to port 0.
REQ-041 Single-byte frame on port 1 with s_terr_in[1]=1 -> phy_terr_out=1 on that byte, FSM enters IFG next clock.

Source files
------------

// File: rtl/eth_tx_arbiter_if.sv
// Bundles the requester-side byte streams, the PHY TX byte stream and the status outputs of the TX arbiter.
// Latency: none, wiring only.
// Backpressure: slave view takes phy_tready_in in and returns s_tready_out to the requesters.
interface eth_tx_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS*8-1:0] s_txd_in;
  logic [NUM_PORTS-1:0]   s_tvalid_in;
  logic [NUM_PORTS-1:0]   s_tlast_in;
  logic [NUM_PORTS-1:0]   s_terr_in;
  logic [NUM_PORTS-1:0]   s_tready_out;
  logic [7:0]             phy_txd_out;
  logic                   phy_tvalid_out;
  logic                   phy_terr_out;
  logic                   phy_tready_in;
  logic [NUM_PORTS-1:0]   grant_out;
  logic [15:0]            frame_cnt_out;
  logic [15:0]            underrun_cnt_out;

  modport slave (
    input  s_txd_in, s_tvalid_in, s_tlast_in, s_terr_in, phy_tready_in,
    output s_tready_out, phy_txd_out, phy_tvalid_out, phy_terr_out,
    output grant_out, frame_cnt_out, underrun_cnt_out
  );

  modport master (
    output s_txd_in, s_tvalid_in, s_tlast_in, s_terr_in, phy_tready_in,
    input  s_tready_out, phy_txd_out, phy_tvalid_out, phy_terr_out,
    input  grant_out, frame_cnt_out, underrun_cnt_out
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter that hands the PHY TX byte path to one requester per frame, with a forced inter-frame gap.
// Latency: one clock from request in IDLE to grant; bytes then pass combinationally from the owner to the PHY.
// Backpressure: phy_tready_in is routed to the owner's s_tready_out only; every other requester sees ready low.
module eth_tx_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int IFG_CYCLES = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  eth_tx_arbiter_if.slave   bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, IFG} state_t;

  state_t               state_q, state_d;
  logic                 rst_s1, rst_s2, rst_n;
  logic [PW-1:0]        last_grant_q, gnt_idx_q, pick_idx;
  logic                 pick_vld;
  int                   cand;
  logic [NUM_PORTS-1:0] grant_q;
  logic [7:0]           ifg_cnt_q;
  logic [15:0]          frame_cnt_q, underrun_cnt_q;
  logic                 started_q, underrun_flag_q;
  logic                 sel_vld, sel_last, sel_err, beat_hs, last_hs;
  logic [7:0]           sel_dat;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rst_s1 <= 1'b0;
      rst_s2 <= 1'b0;
    end else begin
      rst_s1 <= 1'b1;
      rst_s2 <= rst_s1;
    end
  end

  assign rst_n = rst_s2;

  // Owner's stream, selected by the registered grant index.
  assign sel_vld  = bus.s_tvalid_in[gnt_idx_q];
  assign sel_last = bus.s_tlast_in[gnt_idx_q];
  assign sel_err  = bus.s_terr_in[gnt_idx_q];
  assign sel_dat  = bus.s_txd_in[{gnt_idx_q, 3'b000} +: 8];
  assign beat_hs  = (state_q == XFER) && sel_vld && bus.phy_tready_in;
  assign last_hs  = beat_hs && sel_last;

  // Round-robin search: first requester after the previous owner wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!pick_vld && bus.s_tvalid_in[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: grant, hold for the whole frame, then sit out the gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = XFER;
      XFER:    if (last_hs) state_d = IFG;
      IFG:     if (ifg_cnt_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: owner's stream passes through only while transferring.
  always_comb begin
    bus.phy_tvalid_out = 1'b0;
    bus.phy_txd_out    = 8'h00;
    bus.phy_terr_out   = 1'b0;
    bus.s_tready_out   = '0;
    if (state_q == XFER) begin
      bus.phy_tvalid_out = sel_vld;
      bus.phy_txd_out    = sel_dat;
      bus.phy_terr_out   = sel_err & sel_vld;
      bus.s_tready_out   = grant_q & {NUM_PORTS{bus.phy_tready_in}};
    end
  end

  // Grant, gap counter, and frame/underrun statistics.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q         <= '0;
      gnt_idx_q       <= '0;
      last_grant_q    <= PW'(NUM_PORTS - 1);
      ifg_cnt_q       <= 8'd0;
      frame_cnt_q     <= 16'd0;
      underrun_cnt_q  <= 16'd0;
      started_q       <= 1'b0;
      underrun_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q         <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx_q       <= pick_idx;
            last_grant_q    <= pick_idx;
            started_q       <= 1'b0;
            underrun_flag_q <= 1'b0;
          end
        end
        XFER: begin
          if (beat_hs) started_q <= 1'b1;
          // A valid gap once the frame has started counts once per frame.
          if (started_q && !sel_vld && !underrun_flag_q) begin
            underrun_flag_q <= 1'b1;
            if (underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
          end
          if (last_hs) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            grant_q     <= '0;
            ifg_cnt_q   <= 8'(IFG_CYCLES - 1);
          end
        end
        IFG: begin
          if (ifg_cnt_q != 8'd0) ifg_cnt_q <= ifg_cnt_q - 8'd1;
        end
        default: grant_q <= '0;
      endcase
    end
  end

  assign bus.grant_out        = grant_q;
  assign bus.frame_cnt_out    = frame_cnt_q;
  assign bus.underrun_cnt_out = underrun_cnt_q;

endmodule
